// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Provides the receiver state enum, data width and default bit period.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BAUD_DIV  = 868;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_core_if.sv
// Consumer-side bus of the UART receiver: holding register and status.
// master = receiver (drives data/flags), slave = consumer (drives rd_en).
interface uart_rx_core_if
  import uart_pkg::*;
;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      frame_err;
  logic                      overrun;
  logic                      busy;
  logic                      rd_en;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy,
    input  rd_en
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy,
    output rd_en
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// Ports: clk, rst (async high), d (async in), q (synced out, resets to RST_VAL).
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry holding register.
// Ports: clk, rst (async high), uart_rx (raw line), bus (master: data/flags out, rd_en in).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rx,
  uart_rx_core_if.master bus
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  uart_rx_state_t state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bitn, bitn_n;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] data_q;
  logic rxs;
  logic shift, stop_smp;
  logic valid_q, ferr_q, ovr_q;
  logic pop, load, drop;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      if (shift)
        shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitn_n   = bitn;
    shift    = 1'b0;
    stop_smp = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          bitn_n  = '0;
          // A high line at mid start bit is a glitch.
          state_n = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n  = '0;
          shift  = 1'b1;
          bitn_n = bitn + 1'b1;
          if (bitn == 3'd7)
            state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n    = '0;
          stop_smp = 1'b1;
          // Back to IDLE on the stop sample so a new
          // start edge one cycle later is caught.
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop  = bus.rd_en & valid_q;
  assign load = stop_smp & rxs & (~valid_q | bus.rd_en);
  assign drop = stop_smp & rxs & valid_q & ~bus.rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= stop_smp & ~rxs;
      if (load)
        data_q <= shreg;
      if (load)
        valid_q <= 1'b1;
      else if (pop)
        valid_q <= 1'b0;
      if (drop)
        ovr_q <= 1'b1;
      else if (pop)
        ovr_q <= 1'b0;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core with BAUD_DIV = 16.
// Drives serial frames and the read strobe, checks data and flags.
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_core_if bus ();

  uart_rx_core #(.BAUD_DIV(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame, 16 cycles per bit. Edge c is the c-th
  // clock edge after the falling start edge. rd_en is high for
  // edge rd_at only. Reports the edge where rx_valid rose and
  // the frame_err pulse count / first edge.
  task automatic send_frame(
    input  logic [7:0] d,
    input  logic       stop,
    input  int         rd_at,
    output int         rise_at,
    output int         ferr_n,
    output int         ferr_at
  );
    logic [9:0] bits;
    logic       prev;
    bits    = {stop, d, 1'b0};
    prev    = bus.rx_valid;
    rise_at = -1;
    ferr_n  = 0;
    ferr_at = -1;
    for (int c = 0; c < 160; c++) begin
      uart_rx   = bits[c / 16];
      bus.rd_en = (c == rd_at);
      tick();
      if (bus.rx_valid && !prev && rise_at < 0)
        rise_at = c;
      prev = bus.rx_valid;
      if (bus.frame_err) begin
        ferr_n++;
        if (ferr_at < 0) ferr_at = c;
      end
    end
    uart_rx   = 1'b1;
    bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int act;
    rst       = 1'b1;
    uart_rx   = 1'b1;
    bus.rd_en = 1'b0;
    #1;
    n_checks++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err,
         bus.overrun, bus.busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h exp 000",
        {bus.rx_data, bus.rx_valid, bus.frame_err,
         bus.overrun, bus.busy});
    end
    repeat (3) tick();
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.busy || bus.rx_valid || bus.frame_err) act++;
    end
    n_checks++;
    if (act !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: activity cycles %0d exp 0", act);
    end
  endtask

  task automatic test_single();
    int r, fn, fa;
    send_frame(8'hA5, 1'b1, -1, r, fn, fa);
    n_checks++;
    if (r !== 154) begin
      n_fail++;
      $display("FAIL single_rise: edge %0d exp 154", r);
    end
    n_checks++;
    if (bus.rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_data: got %h exp a5", bus.rx_data);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || fn !== 0) begin
      n_fail++;
      $display("FAIL single_flags: busy %b ferr %0d exp 0 0",
        bus.busy, fn);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: valid %b exp 0", bus.rx_valid);
    end
    idle(20);
  endtask

  task automatic test_glitch();
    int bad;
    logic mid_busy;
    bad      = 0;
    mid_busy = 1'b0;
    uart_rx  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) uart_rx = 1'b1;
      tick();
      if (c == 5) mid_busy = bus.busy;
      if (bus.frame_err || bus.rx_valid) bad++;
    end
    n_checks++;
    if (mid_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start: busy %b exp 1", mid_busy);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bad !== 0) begin
      n_fail++;
      $display("FAIL glitch_idle: busy %b flags %0d exp 0 0",
        bus.busy, bad);
    end
  endtask

  task automatic test_frame_err();
    int r, fn, fa;
    send_frame(8'h3C, 1'b0, -1, r, fn, fa);
    n_checks++;
    if (fn !== 1 || fa !== 154) begin
      n_fail++;
      $display("FAIL ferr_pulse: n %0d at %0d exp 1 at 154", fn, fa);
    end
    n_checks++;
    if (bus.rx_valid !== 1'b0 || r !== -1) begin
      n_fail++;
      $display("FAIL ferr_valid: valid %b exp 0", bus.rx_valid);
    end
    idle(40);
  endtask

  task automatic test_overrun();
    int r, fn, fa;
    send_frame(8'h11, 1'b1, -1, r, fn, fa);
    send_frame(8'h22, 1'b1, -1, r, fn, fa);
    n_checks++;
    if (bus.rx_data !== 8'h11 || bus.overrun !== 1'b1 ||
        bus.rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: data %h ovr %b valid %b exp 11 1 1",
        bus.rx_data, bus.overrun, bus.rx_valid);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.rx_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: valid %b ovr %b exp 0 0",
        bus.rx_valid, bus.overrun);
    end
    idle(20);
  endtask

  task automatic test_simultaneous();
    int r, fn, fa;
    send_frame(8'h55, 1'b1, -1, r, fn, fa);
    n_checks++;
    if (bus.rx_data !== 8'h55 || bus.rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_first: data %h valid %b exp 55 1",
        bus.rx_data, bus.rx_valid);
    end
    send_frame(8'h77, 1'b1, 154, r, fn, fa);
    n_checks++;
    if (bus.rx_data !== 8'h77 || bus.rx_valid !== 1'b1 ||
        bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_load: data %h valid %b ovr %b exp 77 1 0",
        bus.rx_data, bus.rx_valid, bus.overrun);
    end
    idle(10);
  endtask

  task automatic test_reset_mid();
    int act;
    uart_rx = 1'b0;
    repeat (50) tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: busy %b valid %b exp 1 1",
        bus.busy, bus.rx_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err,
         bus.overrun, bus.busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h exp 000",
        {bus.rx_data, bus.rx_valid, bus.frame_err,
         bus.overrun, bus.busy});
    end
    uart_rx = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    act = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.busy || bus.rx_valid || bus.frame_err ||
          bus.overrun) act++;
    end
    n_checks++;
    if (act !== 0) begin
      n_fail++;
      $display("FAIL rstmid_idle: activity cycles %0d exp 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
